// File: rtl/pulse_width_decoder.sv
// pulse_width_decoder
// Measures the high width of an asynchronous pulse line in clock cycles and
// presents each measurement as raw and offset-corrected values on a
// valid/ready output. A long low gap produces a zero-width result, and a line
// held high too long is reported as stuck instead of being measured.

module pulse_width_decoder #(
  parameter logic [31:0] OFFSET      = 32'd25000000,
  parameter logic [31:0] MIN_WIDTH   = 32'd2,
  parameter logic [31:0] MAX_WIDTH   = 32'd60000000,
  parameter logic [31:0] GAP_TIMEOUT = 32'd100000000
) (
  input  logic        clock_50_mhz,
  input  logic        reset_n,
  input  logic        pulse_in,
  output logic [31:0] count_raw,
  output logic [31:0] count_signed,
  output logic        count_valid,
  input  logic        count_ready,
  output logic [15:0] frame_count,
  output logic        overrun,
  output logic        stuck
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_STUCK   = 2'd2;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_p_d;
  logic [1:0]  r_state;
  logic [31:0] r_width;
  logic [31:0] r_gap;
  logic        r_stuck;
  logic [31:0] r_raw;
  logic [31:0] r_signed;
  logic        r_valid;
  logic [15:0] r_frame;
  logic        r_overrun;

  logic        w_rise;
  logic        w_fall;
  logic [31:0] w_width_next;
  logic [31:0] w_gap_next;
  logic        w_timeout;
  logic        w_result;
  logic [31:0] w_result_width;
  logic        w_accept;

  // r_sync2 is the synchronized line; r_p_d is its one-cycle-old copy.
  assign w_rise       = r_sync2 & ~r_p_d;
  assign w_fall       = ~r_sync2 & r_p_d;
  assign w_width_next = r_width + 32'd1;
  assign w_gap_next   = r_gap + 32'd1;
  assign w_timeout    = (r_state == ST_IDLE) && !r_sync2 && (w_gap_next == GAP_TIMEOUT);
  assign w_accept     = r_valid & count_ready;

  // Two-flop synchronizer plus the delayed copy used for edge detection.
  always_ff @(posedge clock_50_mhz) begin
    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, not the sensitivity list.
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_p_d   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of its neighbour, forming a real shift chain.
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
      r_p_d   <= r_sync2;
    end
  end

  // Decide whether this cycle produces a result and which width it carries.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_result       = 1'b0;
    w_result_width = 32'd0;
    if (r_state == ST_MEASURE && w_fall && (r_width >= MIN_WIDTH)) begin
      w_result       = 1'b1;
      w_result_width = r_width;
    end else if (w_timeout) begin
      w_result       = 1'b1;
      w_result_width = 32'd0;
    end
  end

  // Measurement FSM with width and gap counters; width saturates at MAX_WIDTH by entering STUCK.
  always_ff @(posedge clock_50_mhz) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_width <= 32'd0;
      r_gap   <= 32'd0;
      r_stuck <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_width <= 32'd1;
            r_gap   <= 32'd0;
          end else if (!r_sync2) begin
            r_gap <= w_timeout ? 32'd0 : w_gap_next;
          end
        end
        ST_MEASURE: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
          end else if (r_sync2) begin
            r_width <= w_width_next;
            if (w_width_next == MAX_WIDTH) begin
              r_state <= ST_STUCK;
              r_stuck <= 1'b1;
            end
          end
        end
        ST_STUCK: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
            r_stuck <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready handshake, frame counter and sticky overrun.
  always_ff @(posedge clock_50_mhz) begin
    if (!reset_n) begin
      r_raw     <= 32'd0;
      r_signed  <= 32'd0;
      r_valid   <= 1'b0;
      r_frame   <= 16'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_frame <= r_frame + 16'd1;
      end
      if (w_result) begin
        if (!r_valid || w_accept) begin
          r_raw    <= w_result_width;
          r_signed <= w_result_width - OFFSET;
          r_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign count_raw    = r_raw;
  assign count_signed = r_signed;
  assign count_valid  = r_valid;
  assign frame_count  = r_frame;
  assign overrun      = r_overrun;
  assign stuck        = r_stuck;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Testbench for pulse_width_decoder. Instance dut_a uses default parameters
// and a result scoreboard; dut_b uses MAX_WIDTH=100, GAP_TIMEOUT=200 for the
// stuck-line and gap-timeout cases. Inputs change 1 time unit after posedge.

module tb_pulse_width_decoder;

  localparam logic [31:0] OFFSET = 32'd25000000;

  typedef struct {
    int unsigned width;
    bit          expect_result;
    logic [31:0] exp_raw;
  } vec_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_a, pulse_a, ready_a;
  logic [31:0] raw_a, sgn_a;
  logic        valid_a, ovr_a, stuck_a;
  logic [15:0] frame_a;

  logic        rst_b, pulse_b, ready_b;
  logic [31:0] raw_b, sgn_b;
  logic        valid_b, ovr_b, stuck_b;
  logic [15:0] frame_b;

  pulse_width_decoder dut_a (
    .clock_50_mhz(clk), .reset_n(rst_a), .pulse_in(pulse_a),
    .count_raw(raw_a), .count_signed(sgn_a), .count_valid(valid_a),
    .count_ready(ready_a), .frame_count(frame_a), .overrun(ovr_a), .stuck(stuck_a)
  );

  pulse_width_decoder #(.MAX_WIDTH(32'd100), .GAP_TIMEOUT(32'd200)) dut_b (
    .clock_50_mhz(clk), .reset_n(rst_b), .pulse_in(pulse_b),
    .count_raw(raw_b), .count_signed(sgn_b), .count_valid(valid_b),
    .count_ready(ready_b), .frame_count(frame_b), .overrun(ovr_b), .stuck(stuck_b)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_on_a(input int width, input int gap);
    pulse_a = 1'b1;
    step(width);
    pulse_a = 1'b0;
    step(gap);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_raw"},    raw_a, 32'd0);
    check({tag, "_signed"}, sgn_a, 32'd0);
    check({tag, "_valid"},  {31'd0, valid_a}, 32'd0);
    check({tag, "_frame"},  {16'd0, frame_a}, 32'd0);
    check({tag, "_overrun"}, {31'd0, ovr_a}, 32'd0);
    check({tag, "_stuck"},  {31'd0, stuck_a}, 32'd0);
  endtask

  // Scoreboard: on every handshake of dut_a, compare against the oldest expected result.
  always @(negedge clk) begin
    if (rst_a && valid_a && ready_a) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got raw %0d expected no result", raw_a);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_raw", raw_a, mon_exp);
        check("result_signed", sgn_a, mon_exp - OFFSET);
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   n_exp;
    int   cyc;

    vecs[0] = '{1000, 1'b1, 32'd1000};
    vecs[1] = '{1,    1'b0, 32'd0};     // glitch below MIN_WIDTH
    vecs[2] = '{50,   1'b1, 32'd50};
    vecs[3] = '{2,    1'b1, 32'd2};     // exactly MIN_WIDTH
    vecs[4] = '{3,    1'b1, 32'd3};
    vecs[5] = '{7,    1'b1, 32'd7};

    rst_a = 1'b0; pulse_a = 1'b0; ready_a = 1'b1;
    rst_b = 1'b0; pulse_b = 1'b0; ready_b = 1'b1;
    step(3);
    check_a_zero("reset");
    rst_a = 1'b1;
    step(3);

    // Table-driven pulses with ready held high.
    n_exp = 0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].expect_result) begin
        exp_q.push_back(vecs[i].exp_raw);
        n_exp++;
      end
      pulse_on_a(int'(vecs[i].width), 12);
    end
    step(10);
    check("table_queue_drained", exp_q.size(), 32'd0);
    check("table_frame_count", {16'd0, frame_a}, n_exp);

    // Overrun: second result arrives while the first is still held.
    rst_a = 1'b0; step(1); rst_a = 1'b1;
    ready_a = 1'b0;
    pulse_on_a(10, 10);
    pulse_on_a(20, 10);
    check("ovr_valid_held", {31'd0, valid_a}, 32'd1);
    check("ovr_raw_kept", raw_a, 32'd10);
    check("ovr_signed_kept", sgn_a, 32'd10 - OFFSET);
    check("ovr_flag", {31'd0, ovr_a}, 32'd1);
    check("ovr_frame_before", {16'd0, frame_a}, 32'd0);
    exp_q.push_back(32'd10);
    ready_a = 1'b1;
    step(3);
    check("ovr_frame_after", {16'd0, frame_a}, 32'd1);
    check("ovr_valid_dropped", {31'd0, valid_a}, 32'd0);
    check("ovr_sticky", {31'd0, ovr_a}, 32'd1);
    check("ovr_queue_drained", exp_q.size(), 32'd0);

    // Reset at width 30 of an 80-cycle pulse.
    rst_a = 1'b0; step(1); rst_a = 1'b1;
    step(5);
    pulse_a = 1'b1;
    step(32);
    rst_a = 1'b0;
    step(1);
    check_a_zero("midreset");
    rst_a = 1'b1;
    // The line is still high after release, so it restarts as a fresh rise:
    // synchronized high samples run from 2 edges after release to the edge after the pin falls.
    exp_q.push_back(32'd47);
    step(47);
    pulse_a = 1'b0;
    step(12);
    exp_q.push_back(32'd40);
    pulse_on_a(40, 12);
    check("midreset_queue_drained", exp_q.size(), 32'd0);
    check("midreset_frame", {16'd0, frame_a}, 32'd2);

    // Stuck line on dut_b (MAX_WIDTH=100).
    rst_b = 1'b0; step(1); rst_b = 1'b1;
    pulse_b = 1'b1;
    step(101);
    check("stuck_before_max", {31'd0, stuck_b}, 32'd0);
    step(1);
    check("stuck_at_max", {31'd0, stuck_b}, 32'd1);
    step(398);
    check("stuck_held", {31'd0, stuck_b}, 32'd1);
    pulse_b = 1'b0;
    step(5);
    check("stuck_released", {31'd0, stuck_b}, 32'd0);
    check("stuck_no_valid", {31'd0, valid_b}, 32'd0);
    check("stuck_no_frame", {16'd0, frame_b}, 32'd0);

    // Gap timeout on dut_b (GAP_TIMEOUT=200): zero results every 200 cycles.
    rst_b = 1'b0; step(1); rst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      for (int t = 0; t < 300; t++) begin
        step(1);
        cyc++;
        if (valid_b) break;
      end
      check("gap_period", cyc, 32'd200);
      check("gap_raw", raw_b, 32'd0);
      check("gap_signed", sgn_b, 32'd0 - OFFSET);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
